// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: load/store size codes and the access FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, ERR_HOLD} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  // func3[1:0] alone sets the access size; the unused codes fall back to a word.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load extract plus sign/zero extend.
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  func3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_en;

  assign half_sel = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  assign sign_en  = ~func3_i[2];

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    byte_sel = ld_word_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = ld_word_i[15:8];
      2'd2:    byte_sel = ld_word_i[23:16];
      2'd3:    byte_sel = ld_word_i[31:24];
      default: byte_sel = ld_word_i[7:0];
    endcase
  end

  always_comb begin
    be_o      = 4'hF;
    wdata_o   = st_data_i;
    ld_data_o = ld_word_i;
    case (f3_size(func3_i))
      SZ_B: begin
        be_o      = 4'b0001 << addr_lo_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{byte_sel[7] & sign_en}}, byte_sel};
      end
      SZ_H: begin
        be_o      = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o   = {2{st_data_i[15:0]}};
        ld_data_o = {{16{half_sel[15] & sign_en}}, half_sel};
      end
      default: begin
        be_o      = 4'hF;
        wdata_o   = st_data_i;
        ld_data_o = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage with req/ack data-memory access, timeout abandon, and the MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into bus errors.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RD_W    = 6,
  parameter int TMO_MAX = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] me_regs_data2,
  input  logic [XLEN-1:0] me_alu_o,
  input  logic [XLEN-1:0] me_alu_o2,
  input  logic            me_mop_en,
  input  logic [RD_W-1:0] me_rd,
  input  logic            me_mem_read,
  input  logic            me_mem_write,
  input  logic            me_mem2reg,
  input  logic            me_regs_write,
  input  logic [2:0]      me_func3_code,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            mem_stall,
  output logic [XLEN-1:0] wb_mem_data,
  output logic [XLEN-1:0] wb_alu_o,
  output logic [XLEN-1:0] wb_alu_o2,
  output logic            wb_mop_en,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_mem2reg,
  output logic            wb_regs_write,
  output logic            wb_bus_err
);

  localparam int CNT_W = $clog2(TMO_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mem_op, is_load, timeout, misaligned, trap, bus_err;
  size_e              op_size;
  logic [XLEN-1:0]    ld_data;

  assign mem_op  = me_mem_read | me_mem_write;
  assign is_load = me_mem_read & ~me_mem_write;
  assign op_size = f3_size(me_func3_code);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = ((op_size == SZ_H) && me_alu_o[0]) ||
                      ((op_size == SZ_W) && (me_alu_o[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign trap    = mem_op & misaligned;
  assign bus_err = timeout | trap;

  // rst gates the handshake directly so a mid-access reset drops req in the same cycle.
  assign dmem_req   = mem_op & (state_q != ERR_HOLD) & ~trap & ~rst;
  assign mem_stall  = mem_op & ~dmem_ack & ~timeout & ~trap & ~rst;
  assign dmem_we    = me_mem_write;
  assign dmem_addr  = {me_alu_o[XLEN-1:2], 2'b00};

  mem_align u_align (
    .func3_i   (me_func3_code),
    .addr_lo_i (me_alu_o[1:0]),
    .st_data_i (me_regs_data2),
    .ld_word_i (dmem_rdata),
    .be_o      (dmem_be),
    .wdata_o   (dmem_wdata),
    .ld_data_o (ld_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    timeout = 1'b0;
    case (state_q)
      IDLE: if (mem_op && !trap && !dmem_ack) state_d = WAIT;
      WAIT: begin
        if (dmem_ack || !mem_op) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(TMO_MAX)) begin
          timeout = 1'b1;
          state_d = ERR_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR_HOLD: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_mem_data   <= '0;
      wb_alu_o      <= '0;
      wb_alu_o2     <= '0;
      wb_mop_en     <= 1'b0;
      wb_rd         <= '0;
      wb_mem2reg    <= 1'b0;
      wb_regs_write <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else if (mem_stall) begin
      wb_mem2reg    <= 1'b0;
      wb_regs_write <= 1'b0;
      wb_bus_err    <= 1'b0;
    end else begin
      wb_mem_data   <= (is_load && !bus_err) ? ld_data : '0;
      wb_alu_o      <= me_alu_o;
      wb_alu_o2     <= me_alu_o2;
      wb_mop_en     <= me_mop_en;
      wb_rd         <= me_rd;
      wb_mem2reg    <= me_mem2reg & ~bus_err;
      wb_regs_write <= me_regs_write & ~bus_err;
      wb_bus_err    <= bus_err;
    end
  end

endmodule
